// File: rtl/axi4_lite_read_arbiter.sv
// rtl/axi4_lite_read_arbiter.sv - round-robin arbiter sharing one AXI4-Lite read port among NUM_REQ requesters
module axi4_lite_read_arbiter #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         NUM_REQ    = 2,
    parameter logic [2:0] ARPROT_VAL = 3'b000
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic [2:0]                    rsp_id,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic [2:0]                    ARPROT,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    busy_q, busy_d;
    logic [NUM_REQ-1:0]      req_grant_q, req_grant_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [2:0]              rsp_id_q, rsp_id_d;
    logic [2:0]              last_grant_q, last_grant_d;

    logic [7:0]              req_valid_ext;
    logic [3:0]              cand;
    logic                    found;
    logic [2:0]              sel;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic [NUM_REQ-1:0]      id_onehot;
    logic [ADDR_WIDTH-1:0]   sel_addr;

    // Search upward from the requester after the last one served, wrapping at NUM_REQ.
    always_comb begin
        req_valid_ext = 8'(req_valid);
        found         = 1'b0;
        sel           = '0;
        cand          = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!found && req_valid_ext[cand[2:0]]) begin
                found = 1'b1;
                sel   = cand[2:0];
            end
        end
    end

    always_comb begin
        sel_addr   = '0;
        sel_onehot = '0;
        id_onehot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_onehot[i] = (sel == 3'(i));
            id_onehot[i]  = (rsp_id_q == 3'(i));
            if (sel == 3'(i)) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        busy_d       = busy_q;
        req_grant_d  = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_resp_d   = rsp_resp_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    araddr_d    = sel_addr;
                    arvalid_d   = 1'b1;
                    req_grant_d = sel_onehot;
                    rsp_id_d    = sel;
                    busy_d      = 1'b1;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (RVALID) begin
                    rsp_data_d   = RDATA;
                    rsp_resp_d   = RRESP;
                    rsp_valid_d  = id_onehot;
                    rready_d     = 1'b0;
                    last_grant_d = rsp_id_q;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            req_grant_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_resp_q   <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= 3'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            req_grant_q  <= req_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_resp_q   <= rsp_resp_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ARADDR    = araddr_q;
    assign ARPROT    = ARPROT_VAL;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign busy      = busy_q;
    assign req_grant = req_grant_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// tb/tb_axi4_lite_read_arbiter.sv - directed self-checking bench for axi4_lite_read_arbiter
module tb_axi4_lite_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN;

    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [1:0]  req_grant, rsp_valid;
    logic [31:0] rsp_data, ARADDR, RDATA;
    logic [1:0]  rsp_resp, RRESP;
    logic [2:0]  rsp_id, ARPROT;
    logic        busy, ARVALID, ARREADY, RVALID, RREADY;

    logic [3:0]   req_valid4;
    logic [127:0] req_addr4;
    logic [3:0]   req_grant4, rsp_valid4;
    logic [31:0]  rsp_data4, ARADDR4;
    logic [1:0]   rsp_resp4;
    logic [2:0]   rsp_id4, ARPROT4;
    logic         busy4, ARVALID4, RREADY4;

    int n_vec = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_read_arbiter #(.NUM_REQ(2)) u_dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_grant(req_grant), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_id(rsp_id), .busy(busy),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    axi4_lite_read_arbiter #(.NUM_REQ(4)) u_dut4 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid4), .req_addr(req_addr4),
        .req_grant(req_grant4), .rsp_valid(rsp_valid4),
        .rsp_data(rsp_data4), .rsp_resp(rsp_resp4), .rsp_id(rsp_id4), .busy(busy4),
        .ARADDR(ARADDR4), .ARPROT(ARPROT4), .ARVALID(ARVALID4), .ARREADY(1'b1),
        .RDATA(32'hCAFE_0004), .RRESP(2'b00), .RVALID(1'b1), .RREADY(RREADY4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn4(input logic [3:0] req, input int exp_id);
        logic [3:0] oh;
        oh = 4'b0001 << exp_id;
        req_valid4 = req;
        @(negedge ACLK);
        check("t6_grant", 32'(req_grant4), 32'(oh));
        check("t6_araddr", ARADDR4, 32'h100 * (exp_id + 1));
        req_valid4 = 4'b0000;
        @(negedge ACLK);
        @(negedge ACLK);
        check("t6_rsp_valid", 32'(rsp_valid4), 32'(oh));
        check("t6_rsp_id", 32'(rsp_id4), 32'(exp_id));
    endtask

    initial begin
        ARESETN    = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        RDATA      = '0;
        RRESP      = '0;
        req_valid4 = '0;
        for (int i = 0; i < 4; i++) req_addr4[i*32 +: 32] = 32'h100 * (i + 1);

        repeat (2) @(negedge ACLK);
        check("rst_arvalid", 32'(ARVALID), 0);
        check("rst_rready", 32'(RREADY), 0);
        check("rst_araddr", ARADDR, 0);
        check("rst_grant", 32'(req_grant), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("arprot", 32'(ARPROT), 0);
        ARESETN = 1'b1;

        // Test 1: single read, subordinate always ready
        @(negedge ACLK);
        req_valid = 2'b01; req_addr[31:0] = 32'h1000;
        ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
        @(negedge ACLK);
        check("t1_grant", 32'(req_grant), 32'h1);
        check("t1_araddr", ARADDR, 32'h1000);
        check("t1_arvalid", 32'(ARVALID), 1);
        check("t1_busy", 32'(busy), 1);
        req_valid = 2'b00;
        @(negedge ACLK);
        check("t1_rready", 32'(RREADY), 1);
        check("t1_arvalid_lo", 32'(ARVALID), 0);
        check("t1_grant_lo", 32'(req_grant), 0);
        check("t1_rsp_early", 32'(rsp_valid), 0);
        @(negedge ACLK);
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("t1_rsp_id", 32'(rsp_id), 0);
        check("t1_rready_lo", 32'(RREADY), 0);
        check("t1_busy_lo", 32'(busy), 0);
        @(negedge ACLK);
        check("t1_rsp_pulse", 32'(rsp_valid), 0);
        check("t1_data_hold", rsp_data, 32'hDEAD_BEEF);

        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Test 2: both requesting continuously, grants alternate
        req_valid = 2'b11; req_addr = {32'h20, 32'h10}; RDATA = 32'hA5;
        for (int t = 0; t < 4; t++) begin
            @(negedge ACLK);
            check("t2_grant", 32'(req_grant), (t % 2 == 0) ? 32'h1 : 32'h2);
            check("t2_araddr", ARADDR, (t % 2 == 0) ? 32'h10 : 32'h20);
            check("t2_rsp_lo", 32'(rsp_valid), 0);
            @(negedge ACLK);
            check("t2_rready", 32'(RREADY), 1);
            @(negedge ACLK);
            check("t2_rsp_valid", 32'(rsp_valid), (t % 2 == 0) ? 32'h1 : 32'h2);
            check("t2_idle_busy", 32'(busy), 0);
            check("t2_grant_lo", 32'(req_grant), 0);
            if (t == 3) req_valid = 2'b00;
        end

        // Test 3: ARREADY held low for 5 cycles
        req_valid = 2'b10; req_addr[63:32] = 32'h3000; ARREADY = 1'b0; RDATA = 32'h33;
        @(negedge ACLK);
        check("t3_grant", 32'(req_grant), 32'h2);
        req_valid = 2'b00; req_addr[63:32] = 32'hFFFF_FFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            check("t3_arvalid", 32'(ARVALID), 1);
            check("t3_araddr", ARADDR, 32'h3000);
            check("t3_rready_lo", 32'(RREADY), 0);
        end
        ARREADY = 1'b1;
        @(negedge ACLK);
        check("t3_rready", 32'(RREADY), 1);
        check("t3_arvalid_lo", 32'(ARVALID), 0);
        @(negedge ACLK);
        check("t3_rsp_valid", 32'(rsp_valid), 32'h2);
        check("t3_rsp_id", 32'(rsp_id), 1);
        check("t3_rsp_data", rsp_data, 32'h33);

        // Test 4: RVALID delayed 7 cycles, SLVERR passed through
        req_valid = 2'b01; req_addr[31:0] = 32'h4000; RVALID = 1'b0;
        RRESP = 2'b10; RDATA = 32'h55;
        @(negedge ACLK);
        check("t4_grant", 32'(req_grant), 32'h1);
        req_valid = 2'b00;
        for (int c = 0; c < 7; c++) begin
            @(negedge ACLK);
            check("t4_rready", 32'(RREADY), 1);
            check("t4_rsp_lo", 32'(rsp_valid), 0);
        end
        RVALID = 1'b1;
        @(negedge ACLK);
        check("t4_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t4_rsp_resp", 32'(rsp_resp), 32'h2);
        check("t4_rsp_data", rsp_data, 32'h55);
        check("t4_rsp_id", 32'(rsp_id), 0);
        RVALID = 1'b0;

        // Test 5: asynchronous reset while in DATA
        req_valid = 2'b10; req_addr[63:32] = 32'h5000;
        @(negedge ACLK);
        check("t5_grant", 32'(req_grant), 32'h2);
        req_valid = 2'b00;
        @(negedge ACLK);
        check("t5_rready", 32'(RREADY), 1);
        #2 ARESETN = 1'b0;
        #1;
        check("t5_rst_rready", 32'(RREADY), 0);
        check("t5_rst_arvalid", 32'(ARVALID), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_rsp_valid", 32'(rsp_valid), 0);
        check("t5_rst_rsp_data", rsp_data, 0);
        check("t5_rst_rsp_resp", 32'(rsp_resp), 0);
        @(negedge ACLK);
        ARESETN = 1'b1; req_valid = 2'b11; req_addr[31:0] = 32'h10; RVALID = 1'b1;
        @(negedge ACLK);
        check("t5_grant_after", 32'(req_grant), 32'h1);
        check("t5_araddr_after", ARADDR, 32'h10);
        req_valid = 2'b00;
        @(negedge ACLK);
        @(negedge ACLK);
        check("t5_rsp_valid", 32'(rsp_valid), 32'h1);

        // Test 6: four requesters, rotation and wrap-around
        txn4(4'b0010, 1);
        txn4(4'b1010, 3);
        txn4(4'b0011, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
